instr_fetch: RTL and testbench

- Downstream consumer of the program counter's `count` output.
- Holds a loadable 256-byte program memory and fetches the 4-byte instruction at the presented PC: opcode, arg1, arg2, dest.
- Presents the instruction to the execute stage with a valid/ready handshake.
- Program bytes are loaded through a dedicated write port while the machine is stopped or running.

---
 rtl/instr_fetch.sv | 136 +++++++++++++
 tb/tb_instr_fetch.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: loadable 256-byte program memory, fetches one byte per
// cycle into opcode/arg1/arg2/dest and hands the instruction over with valid/ready.
module instr_fetch #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int INSTR_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    input  logic              PROG_WE,
    input  logic [ADDR_W-1:0] PROG_ADDR,
    input  logic [DATA_W-1:0] PROG_DATA,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] opcode,
    output logic [DATA_W-1:0] arg1,
    output logic [DATA_W-1:0] arg2,
    output logic [DATA_W-1:0] dest,
    output logic              instr_valid,
    output logic              busy,
    output logic              overrun
);

    localparam int IDX_W = $clog2(INSTR_BYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INSTR_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                                r_state;
    state_t                                w_state_next;
    logic [ADDR_W-1:0]                     r_base;
    logic [ADDR_W-1:0]                     w_base_next;
    logic [IDX_W-1:0]                      r_byte_idx;
    logic [IDX_W-1:0]                      w_idx_next;
    logic                                  r_overrun;
    logic                                  w_overrun_next;
    logic                                  r_busy;
    logic                                  r_valid;
    logic [INSTR_BYTES-1:0][DATA_W-1:0]    r_fields;
    logic [ADDR_W-1:0]                     w_rd_addr;

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Address arithmetic wraps naturally at ADDR_W bits.
    assign w_rd_addr = r_base + ADDR_W'(r_byte_idx);

    // Not reset: program contents must survive rst.
    always_ff @(posedge clk) begin
        if (PROG_WE) begin
            r_mem[PROG_ADDR] <= PROG_DATA;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_base_next    = r_base;
        w_idx_next     = r_byte_idx;
        w_overrun_next = r_overrun;
        case (r_state)
            S_IDLE: begin
                if (pc_valid) begin
                    w_state_next = S_FETCH;
                    w_base_next  = pc;
                    w_idx_next   = '0;
                end
            end
            S_FETCH: begin
                if (pc_valid) begin
                    w_overrun_next = 1'b1;
                end
                w_idx_next = r_byte_idx + IDX_W'(1);
                if (r_byte_idx == IDX_LAST) begin
                    w_state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    if (pc_valid) begin
                        w_state_next = S_FETCH;
                        w_base_next  = pc;
                        w_idx_next   = '0;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else if (pc_valid) begin
                    w_overrun_next = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // busy/instr_valid are registered decodes of the next state, so no input reaches an output combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_byte_idx <= '0;
            r_overrun  <= 1'b0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_base     <= w_base_next;
            r_byte_idx <= w_idx_next;
            r_overrun  <= w_overrun_next;
            r_busy     <= (w_state_next == S_FETCH);
            r_valid    <= (w_state_next == S_HOLD);
        end
    end

    // Single registered read port; a same-edge write is seen only by later bytes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fields <= '0;
        end else if (r_state == S_FETCH) begin
            r_fields[r_byte_idx] <= r_mem[w_rd_addr];
        end
    end

    assign opcode      = r_fields[0];
    assign arg1        = r_fields[1];
    assign arg2        = r_fields[2];
    assign dest        = r_fields[3];
    assign instr_valid = r_valid;
    assign busy        = r_busy;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a reference copy of program memory feeds a
// scoreboard of expected instructions, compared when instr_valid is observed.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] pc;
    logic       pc_valid;
    logic       PROG_WE;
    logic [7:0] PROG_ADDR;
    logic [7:0] PROG_DATA;
    logic       instr_ready;
    logic [7:0] opcode;
    logic [7:0] arg1;
    logic [7:0] arg2;
    logic [7:0] dest;
    logic       instr_valid;
    logic       busy;
    logic       overrun;

    logic [7:0]  mem_model [256];
    logic [31:0] sb_q [$];
    logic [31:0] last_exp;
    int          n_total = 0;
    int          n_bad   = 0;

    instr_fetch #(
        .ADDR_W(8),
        .DATA_W(8),
        .INSTR_BYTES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pc(pc),
        .pc_valid(pc_valid),
        .PROG_WE(PROG_WE),
        .PROG_ADDR(PROG_ADDR),
        .PROG_DATA(PROG_DATA),
        .instr_ready(instr_ready),
        .opcode(opcode),
        .arg1(arg1),
        .arg2(arg2),
        .dest(dest),
        .instr_valid(instr_valid),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fields();
        return {opcode, arg1, arg2, dest};
    endfunction

    task automatic prog_write(input logic [7:0] a, input logic [7:0] d);
        PROG_WE   = 1'b1;
        PROG_ADDR = a;
        PROG_DATA = d;
        tick();
        PROG_WE   = 1'b0;
        mem_model[a] = d;
    endtask

    task automatic issue_fetch(input logic [7:0] a);
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        a3 = a + 8'd3;
        pc       = a;
        pc_valid = 1'b1;
        sb_q.push_back({mem_model[a], mem_model[a1], mem_model[a2], mem_model[a3]});
        tick();
        pc_valid = 1'b0;
    endtask

    // Waits (bounded) for instr_valid, checks latency, busy cycles and the scoreboard head.
    task automatic wait_instr(input string tag, input int exp_lat);
        int n = 0;
        int n_busy = 0;
        while (!instr_valid && n < 20) begin
            if (busy) n_busy++;
            tick();
            n++;
        end
        check_eq({tag, "_valid"}, 32'(instr_valid), 32'd1);
        check_eq({tag, "_lat"}, 32'(n), 32'(exp_lat));
        check_eq({tag, "_busy_cycles"}, 32'(n_busy), 32'(exp_lat));
        check_eq({tag, "_busy_done"}, 32'(busy), 32'd0);
        check_eq({tag, "_qsize"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            last_exp = sb_q.pop_front();
            check_eq({tag, "_fields"}, fields(), last_exp);
            $display("xfer %s got=%h exp=%h lat=%0d", tag, fields(), last_exp, n);
        end
    endtask

    initial begin
        rst         = 1'b1;
        pc          = '0;
        pc_valid    = 1'b0;
        PROG_WE     = 1'b0;
        PROG_ADDR   = '0;
        PROG_DATA   = '0;
        instr_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem_model[i] = 8'h00;
        tick();
        tick();
        check_eq("rst_fields", fields(), 32'h0);
        check_eq("rst_flags", {29'b0, instr_valid, busy, overrun}, 32'h0);
        rst = 1'b0;
        tick();

        // Program load: all bytes written so reference and DUT agree everywhere used.
        for (int i = 0; i < 256; i++) prog_write(8'(i), 8'(i * 7 + 3));
        prog_write(8'h10, 8'hA1);
        prog_write(8'h11, 8'hB2);
        prog_write(8'h12, 8'hC3);
        prog_write(8'h13, 8'hD4);
        prog_write(8'hFE, 8'h01);
        prog_write(8'hFF, 8'h02);
        prog_write(8'h00, 8'h03);
        prog_write(8'h01, 8'h04);
        tick();

        // Basic fetch
        issue_fetch(8'h10);
        check_eq("basic_busy_start", 32'(busy), 32'd1);
        wait_instr("basic", 4);
        check_eq("basic_const", last_exp, 32'hA1B2C3D4);
        check_eq("basic_overrun", 32'(overrun), 32'd0);
        tick();
        check_eq("basic_drop", 32'(instr_valid), 32'd0);

        // Wrap around the top of memory
        issue_fetch(8'hFE);
        wait_instr("wrap", 4);
        check_eq("wrap_const", last_exp, 32'h01020304);
        tick();

        // Chained fetch from HOLD, plus a strobe dropped during FETCH
        prog_write(8'h20, 8'h5A);
        prog_write(8'h23, 8'hE7);
        issue_fetch(8'h10);
        wait_instr("chain_a", 4);
        issue_fetch(8'h20);
        check_eq("chain_no_idle_busy", 32'(busy), 32'd1);
        check_eq("chain_no_idle_valid", 32'(instr_valid), 32'd0);
        pc       = 8'h30;
        pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        wait_instr("chain_b", 3);
        check_eq("chain_overrun", 32'(overrun), 32'd1);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq("chain_no_extra", {30'b0, instr_valid, busy}, 32'h0);
        end

        // Backpressure: clear overrun with rst first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("bp_overrun_cleared", 32'(overrun), 32'd0);
        instr_ready = 1'b0;
        issue_fetch(8'h10);
        wait_instr("bp", 4);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                pc       = 8'h20;
                pc_valid = 1'b1;
            end
            tick();
            pc_valid = 1'b0;
            check_eq("bp_hold_valid", {30'b0, instr_valid, busy}, 32'h2);
            check_eq("bp_hold_fields", fields(), last_exp);
        end
        check_eq("bp_overrun", 32'(overrun), 32'd1);
        instr_ready = 1'b1;
        tick();
        check_eq("bp_release", {30'b0, instr_valid, busy}, 32'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("bp_idle", {30'b0, instr_valid, busy}, 32'h0);
        end

        // Write/fetch collision on the opcode byte: read-before-write
        issue_fetch(8'h10);
        PROG_WE   = 1'b1;
        PROG_ADDR = 8'h10;
        PROG_DATA = 8'h55;
        tick();
        PROG_WE = 1'b0;
        mem_model[8'h10] = 8'h55;
        wait_instr("coll_old", 3);
        check_eq("coll_old_op", 32'(opcode), 32'hA1);
        issue_fetch(8'h10);
        wait_instr("coll_new", 4);
        check_eq("coll_new_op", 32'(opcode), 32'h55);
        tick();
        prog_write(8'h10, 8'hA1);
        tick();

        // Reset in the middle of a fetch
        issue_fetch(8'h10);
        tick();
        tick();
        check_eq("rstmid_partial_op", 32'(opcode), 32'hA1);
        rst = 1'b1;
        #1;
        check_eq("rstmid_fields", fields(), 32'h0);
        check_eq("rstmid_flags", {29'b0, instr_valid, busy, overrun}, 32'h0);
        sb_q.delete();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("rstmid_quiet", {30'b0, instr_valid, busy}, 32'h0);
        end
        issue_fetch(8'h10);
        wait_instr("rstmid_refetch", 4);
        check_eq("rstmid_retained", last_exp, 32'hA1B2C3D4);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
